// File: rtl/f36m_pow3k.sv
// f36m_pow3k: computes c = a^(3^k) in GF(3^{6M}) with one Frobenius cubing per clock.
// Optional macro F36M_POW3K_MODRED_EN reduces k modulo 6M at load to shorten long runs.
`ifndef W6
`define W6 1163
`endif

module f36m_pow3k #(
  parameter int unsigned KW    = 10,
  parameter int unsigned MOD6M = 582
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [`W6:0]  a,
  input  logic [KW-1:0] k,
  output logic [`W6:0]  c,
  output logic          done,
  output logic          busy
);
  // GF(3^M) = GF(3)[x]/(x^97 + x^12 + 2); GF(3^2M) = GF(3^M)[i]/(i^2+1);
  // GF(3^6M) = GF(3^2M)[y]/(y^3 - y - 1). Coefficient i sits at bits [2i+1:2i].
  localparam int unsigned M   = 97;
  localparam int unsigned W1  = 2 * M;
  localparam int unsigned W2  = 2 * W1;
  localparam int unsigned TW  = 2 * (3 * M - 2);
  localparam int unsigned TAP = 12;

  if ((MOD6M != 6 * M) || (`W6 + 1 != 6 * W1)) begin : g_cfg_chk
    $error("f36m_pow3k: MOD6M or W6 inconsistent with M=97");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [KW-1:0]   cnt;
  logic [`W6:0]    acc;
  logic [`W6:0]    acc_cube;
  logic [KW-1:0]   k_load;

  function automatic logic [1:0] gf3_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = 3'(x) + 3'(y);
    return (s >= 3'd3) ? 2'(s - 3'd3) : 2'(s);
  endfunction

  // Swapping the two code bits maps 1 <-> 2 and leaves 0 alone.
  function automatic logic [1:0] gf3_neg(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  function automatic logic [W1-1:0] f3m_add(input logic [W1-1:0] x, input logic [W1-1:0] y);
    logic [W1-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = gf3_add(x[2*i +: 2], y[2*i +: 2]);
    return r;
  endfunction

  function automatic logic [W1-1:0] f3m_neg(input logic [W1-1:0] x);
    logic [W1-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = gf3_neg(x[2*i +: 2]);
    return r;
  endfunction

  // Spread coefficient i to degree 3i, then fold top-down using x^97 = 2x^12 + 1.
  function automatic logic [W1-1:0] f3m_cube(input logic [W1-1:0] x);
    logic [TW-1:0] t;
    logic [1:0]    v;
    t = '0;
    for (int i = 0; i < M; i++) t[6*i +: 2] = x[2*i +: 2];
    for (int d = 3 * M - 3; d >= M; d--) begin
      v = t[2*d +: 2];
      t[2*(d-M) +: 2]     = gf3_add(t[2*(d-M) +: 2], v);
      t[2*(d-M+TAP) +: 2] = gf3_add(t[2*(d-M+TAP) +: 2], gf3_neg(v));
    end
    return t[W1-1:0];
  endfunction

  function automatic logic [W2-1:0] f32m_add(input logic [W2-1:0] x, input logic [W2-1:0] y);
    return {f3m_add(x[W2-1:W1], y[W2-1:W1]), f3m_add(x[W1-1:0], y[W1-1:0])};
  endfunction

  function automatic logic [W2-1:0] f32m_neg(input logic [W2-1:0] x);
    return {f3m_neg(x[W2-1:W1]), f3m_neg(x[W1-1:0])};
  endfunction

  // (p + q i)^3 = p^3 - q^3 i
  function automatic logic [W2-1:0] f32m_cube(input logic [W2-1:0] x);
    return {f3m_neg(f3m_cube(x[W2-1:W1])), f3m_cube(x[W1-1:0])};
  endfunction

  function automatic logic [`W6:0] f36m_cubic(input logic [`W6:0] x);
    logic [W2-1:0] v0, v1, v2;
    v0 = f32m_cube(x[W2-1:0]);
    v1 = f32m_cube(x[2*W2-1:W2]);
    v2 = f32m_cube(x[3*W2-1:2*W2]);
    return {v2, f32m_add(v1, f32m_neg(v2)), f32m_add(f32m_add(v0, v1), v2)};
  endfunction

  always_comb acc_cube = f36m_cubic(acc);

  // a^(3^(6M)) = a, so k can be folded into [0, 6M) without changing the result.
`ifdef F36M_POW3K_MODRED_EN
  always_comb k_load = (k >= KW'(MOD6M)) ? (k - KW'(MOD6M)) : k;
`else
  always_comb k_load = k;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      c     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= a;
            cnt   <= k_load;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            acc <= acc_cube;
            cnt <= cnt - KW'(1);
          end else begin
            c     <= acc;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f36m_pow3k.sv
// Directed bench for f36m_pow3k; reference cubing built from a table of x^(3i) mod f
// obtained by repeated multiplication by x.
`ifndef W6
`define W6 1163
`endif

module tb_f36m_pow3k;
  localparam int M  = 97;
  localparam int W1 = 2 * M;
  localparam int WN = 6 * W1;
  localparam int KW = 10;
`ifdef F36M_POW3K_MODRED_EN
  localparam int LAT583 = 2;
  localparam int LAT582 = 1;
`else
  localparam int LAT583 = 584;
  localparam int LAT582 = 583;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [`W6:0]  a     = '0;
  logic [KW-1:0] k     = '0;
  logic [`W6:0]  c;
  logic          done;
  logic          busy;

  int total = 0;
  int fails = 0;
  int lat;
  logic [WN-1:0] ra, rb, exp_v, one_v, hv;
  logic [W1-1:0] xp [M];

  f36m_pow3k dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .k     (k),
    .c     (c),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] g_add(input logic [1:0] p, input logic [1:0] q);
    int s;
    s = (int'(p) + int'(q)) % 3;
    return 2'(s);
  endfunction

  function automatic logic [1:0] g_neg(input logic [1:0] p);
    return 2'((3 - int'(p)) % 3);
  endfunction

  function automatic logic [W1-1:0] e1_add(input logic [W1-1:0] p, input logic [W1-1:0] q);
    logic [W1-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = g_add(p[2*i +: 2], q[2*i +: 2]);
    return r;
  endfunction

  function automatic logic [W1-1:0] e1_neg(input logic [W1-1:0] p);
    logic [W1-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = g_neg(p[2*i +: 2]);
    return r;
  endfunction

  // p * x mod (x^97 + x^12 + 2): the overflow h becomes h*(2x^12 + 1).
  function automatic logic [W1-1:0] mulx(input logic [W1-1:0] p);
    logic [W1-1:0] r;
    logic [1:0]    h;
    h = p[W1-1 -: 2];
    r = {p[W1-3:0], 2'b00};
    r[1:0]   = g_add(r[1:0], h);
    r[25:24] = g_add(r[25:24], g_neg(h));
    return r;
  endfunction

  function automatic logic [W1-1:0] ref_f3m(input logic [W1-1:0] p);
    logic [W1-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) begin
      if (p[2*i +: 2] == 2'd1) r = e1_add(r, xp[i]);
      else if (p[2*i +: 2] == 2'd2) r = e1_add(r, e1_neg(xp[i]));
    end
    return r;
  endfunction

  function automatic logic [WN-1:0] ref_cube(input logic [WN-1:0] p);
    logic [W1-1:0] re [3];
    logic [W1-1:0] im [3];
    logic [W1-1:0] c0r, c0i, c1r, c1i;
    for (int j = 0; j < 3; j++) begin
      re[j] = ref_f3m(p[2*j*W1 +: W1]);
      im[j] = e1_neg(ref_f3m(p[(2*j+1)*W1 +: W1]));
    end
    c0r = e1_add(e1_add(re[0], re[1]), re[2]);
    c0i = e1_add(e1_add(im[0], im[1]), im[2]);
    c1r = e1_add(re[1], e1_neg(re[2]));
    c1i = e1_add(im[1], e1_neg(im[2]));
    return {im[2], re[2], c1i, c1r, c0i, c0r};
  endfunction

  function automatic logic [WN-1:0] ref_pow(input logic [WN-1:0] p, input int n);
    logic [WN-1:0] r;
    r = p;
    for (int i = 0; i < n; i++) r = ref_cube(r);
    return r;
  endfunction

  function automatic logic [WN-1:0] rand6();
    logic [WN-1:0] r;
    for (int i = 0; i < 3 * W1; i++) r[2*i +: 2] = 2'($urandom_range(2, 0));
    return r;
  endfunction

  task automatic chk_v(input string tag, input logic [WN-1:0] obs, input logic [WN-1:0] expv);
    int idx;
    idx = 0;
    for (int i = 3 * W1 - 1; i >= 0; i--) if (obs[2*i +: 2] !== expv[2*i +: 2]) idx = i;
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: coef %0d observed %b expected %b", tag, idx, obs[2*idx +: 2], expv[2*idx +: 2]);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive start for one edge (t0); afterwards scramble a/k to show they are not re-sampled.
  task automatic start_run(input logic [WN-1:0] av, input int kv);
    @(negedge clk);
    a = av;
    k = KW'(kv);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = rand6();
    k = KW'($urandom_range(1023, 0));
  endtask

  task automatic wait_done(input int max, inout int cyc);
    while (done !== 1'b1 && cyc < max) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    logic [W1-1:0] p;
    p = '0;
    p[1:0] = 2'b01;
    for (int i = 0; i < M; i++) begin
      xp[i] = p;
      p = mulx(mulx(mulx(p)));
    end
    one_v = '0;
    one_v[1:0] = 2'b01;

    // reset state
    #12;
    chk_i("rst_done", int'(done), 0);
    chk_i("rst_busy", int'(busy), 0);
    chk_v("rst_c", c, '0);
    @(negedge clk);
    reset = 1'b0;

    // k=0: immediate completion, busy for one cycle
    ra = rand6();
    start_run(ra, 0);
    chk_i("k0_busy_hi", int'(busy), 1);
    lat = 0;
    wait_done(50, lat);
    chk_i("k0_lat", lat, 1);
    chk_i("k0_busy_lo", int'(busy), 0);
    chk_v("k0_c", c, ra);

    // k=1 random operand
    ra = rand6();
    start_run(ra, 1);
    lat = 0;
    wait_done(50, lat);
    chk_i("k1_lat", lat, 2);
    chk_v("k1_c", c, ref_cube(ra));

    // k=1 hand vectors: x -> x^3, x^33 -> x^99 = 2x^14 + x^2, imaginary x -> -x^3, y^2 x
    hv = '0; hv[3:2] = 2'b01;
    exp_v = '0; exp_v[7:6] = 2'b01;
    start_run(hv, 1); lat = 0; wait_done(50, lat);
    chk_v("hand_x", c, exp_v);
    hv = '0; hv[67:66] = 2'b01;
    exp_v = '0; exp_v[5:4] = 2'b01; exp_v[29:28] = 2'b10;
    start_run(hv, 1); lat = 0; wait_done(50, lat);
    chk_v("hand_x33", c, exp_v);
    hv = '0; hv[197:196] = 2'b01;
    exp_v = '0; exp_v[201:200] = 2'b10;
    start_run(hv, 1); lat = 0; wait_done(50, lat);
    chk_v("hand_ix", c, exp_v);
    hv = '0; hv[779:778] = 2'b01;
    exp_v = '0; exp_v[7:6] = 2'b01; exp_v[395:394] = 2'b10; exp_v[783:782] = 2'b01;
    start_run(hv, 1); lat = 0; wait_done(50, lat);
    chk_v("hand_y2x", c, exp_v);

    // k=49 random, one, zero
    ra = rand6();
    start_run(ra, 49); lat = 0; wait_done(200, lat);
    chk_i("k49_lat", lat, 50);
    chk_v("k49_c", c, ref_pow(ra, 49));
    start_run(one_v, 49); lat = 0; wait_done(200, lat);
    chk_v("k49_one", c, one_v);
    start_run('0, 49); lat = 0; wait_done(200, lat);
    chk_v("k49_zero", c, '0);

    // start pulsed mid-run is ignored
    ra = rand6();
    rb = rand6();
    start_run(ra, 20);
    lat = 0;
    repeat (4) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    a = rb; k = KW'(3); start = 1'b1;
    @(posedge clk); #1; lat++;
    start = 1'b0;
    wait_done(200, lat);
    chk_i("ign_lat", lat, 21);
    chk_v("ign_c", c, ref_pow(ra, 20));

    // asynchronous reset mid-run
    start_run(rand6(), 30);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_i("arst_done", int'(done), 0);
    chk_i("arst_busy", int'(busy), 0);
    chk_v("arst_c", c, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rb = rand6();
    start_run(rb, 2); lat = 0; wait_done(50, lat);
    chk_i("post_lat", lat, 3);
    chk_v("post_c", c, ref_pow(rb, 2));

    // start held high: done pulses one cycle, cleared by the next load
    @(negedge clk);
    a = ra; k = '0; start = 1'b1;
    @(posedge clk); #1;
    chk_i("hold_busy", int'(busy), 1);
    @(posedge clk); #1;
    chk_i("hold_done1", int'(done), 1);
    @(posedge clk); #1;
    chk_i("hold_done0", int'(done), 0);
    @(posedge clk); #1;
    chk_i("hold_done2", int'(done), 1);
    chk_v("hold_c", c, ra);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;

    // exponent wrap: a^(3^583) = a^3, a^(3^582) = a
    ra = rand6();
    start_run(ra, 583); lat = 0; wait_done(800, lat);
    chk_i("k583_lat", lat, LAT583);
    chk_v("k583_c", c, ref_cube(ra));
    start_run(ra, 582); lat = 0; wait_done(800, lat);
    chk_i("k582_lat", lat, LAT582);
    chk_v("k582_c", c, ra);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
